axis_divider: RTL and testbench
===============================

Name: axis_divider

Overview:
- Iterative 32-bit integer divider with AXI-stream-style valid-only inputs and output (no tready).
- The HI/LO multiply-divide bridge instantiates it twice:
  - SIGNED=1 as "Divider" for DIV.
  - SIGNED=0 as "Divider_Unsighed" for DIVU.
- One operation in flight; fixed 34-cycle latency; the result is held until the next result.

Parameters:
- SIGNED, 1, 1 = two's-complement division, 0 = unsigned division.
- WIDTH, 32, operand width; tdata is 2*WIDTH wide.

Ports:
- aclk  in  1  clock, rising edge.
- areset  in  1  reset.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tdata  in  32  divisor.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tdata  in  32  dividend.
- m_axis_dout_tvalid  out  1  one-cycle result strobe.
- m_axis_dout_tdata  out  64  {quotient[63:32], remainder[31:0]}.

Behaviour:
- Clock and reset: one clock, aclk; reset is synchronous and active-high on areset.
- Reset values: m_axis_dout_tvalid=0, m_axis_dout_tdata=0, state IDLE. Reset mid-operation aborts the operation; no tvalid is produced for it.
- Accept rule: an operation is accepted at a rising edge when in IDLE and both tvalids are 1. If only one tvalid is 1, nothing is accepted. Inputs presented while BUSY are ignored (not queued, no restart).
- States:
  - IDLE.
  - PREP (1 cycle): latch magnitudes and result signs.
  - ITER (32 cycles): one restoring shift-subtract step per cycle.
  - FIX (1 cycle): apply signs and register the output.
- Latency: accept at edge E0 → m_axis_dout_tvalid=1 for exactly the one cycle following edge E34.
- Return to IDLE: the block returns to IDLE at edge E34. A new operation presented while tvalid is high is accepted at edge E35.
- Output hold: m_axis_dout_tdata is updated only at E34 and holds its value until the next completion.
- Unsigned (SIGNED=0): q = floor(a/b), r = a - q*b.
- Signed (SIGNED=1):
  - Quotient truncates toward zero; remainder takes the dividend's sign (MIPS DIV semantics).
  - Computed on magnitudes: |x| as 33-bit so |−2^31| is exact. Quotient is negated when the operand signs differ; remainder is negated when the dividend is negative.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Divide by zero, both modes: q=0xFFFFFFFF, r=dividend, same latency, no error flag.
- tdata byte order: the bridge swaps the halves, so that HI = remainder and LO = quotient. The packing above must not change.

Decomposition:
- Shared package div_pkg: DIV_WIDTH=32, DIV_LATENCY=34, and the state enum {IDLE, PREP, ITER, FIX}.
- One natural sub-module: div_core_unsigned, the 32-step restoring divider with start/done handshake.
  - axis_divider wraps it with sign handling and the AXI-stream ports.
- Divider and Divider_Unsighed are thin wrappers that fix SIGNED.

Test Plan:
- SIGNED=0, 100/7 → tvalid exactly 34 cycles after accept, tdata=0x0000000E_00000002; tvalid low on the following cycle while tdata holds.
- SIGNED=1:
  - −7/2 → tdata=0xFFFFFFFD_FFFFFFFF.
  - 7/−2 → 0xFFFFFFFD_00000001.
  - 0x80000000/0xFFFFFFFF → 0x80000000_00000000.
- SIGNED=0:
  - 0xFFFFFFFF/1 → 0xFFFFFFFF_00000000.
  - 5/0 → 0xFFFFFFFF_00000005.
- SIGNED=1, 0xFFFFFFFB/0 → 0xFFFFFFFF_FFFFFFFB.
- Busy handling:
  - Issue 100/7, then 9/3 at cycle 10 → only one tvalid, at cycle 34, with 100/7's result.
  - 9/3 issued in the tvalid cycle → accepted; tdata=0x00000003_00000000 exactly 34 cycles later.
- Reset and partial inputs:
  - Assert areset at cycle 20 of an operation → tvalid and tdata become 0 and no strobe ever follows; a subsequent operation completes normally.
  - Only one input tvalid high → no accept, no output.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } div_state_t;

endpackage

// File: rtl/div_core_unsigned.sv
// Restoring unsigned divider: WIDTH shift-subtract steps, the first taken on the start edge.
module div_core_unsigned
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] rem_in;
  logic [WIDTH-1:0] quo_in;
  logic [WIDTH-1:0] dsr_in;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // On start the step operates on the port operands, so the first step costs no extra cycle.
  always_comb begin
    rem_in  = start ? '0 : rem_reg;
    quo_in  = start ? dividend : quo_reg;
    dsr_in  = start ? divisor : dsr_reg;
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_in};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rem_reg   <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start || busy_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        dsr_reg <= dsr_in;
      end
      if (start) begin
        busy_reg  <= 1'b1;
        count_reg <= CW'(1);
      end else if (busy_reg) begin
        count_reg <= count_reg + 1'b1;
        if (count_reg == LAST_STEP) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done      = done_reg;
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/axis_divider.sv
// Valid-only stream divider: sign handling around the unsigned core, fixed 34-cycle latency.
module axis_divider
  import div_pkg::*;
#(
  parameter int SIGNED = 1,
  parameter int WIDTH  = DIV_WIDTH
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  div_state_t         state_reg;
  logic [WIDTH-1:0]   dividend_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic               q_neg_reg;
  logic               r_neg_reg;
  logic               zero_reg;
  logic               tvalid_reg;
  logic [2*WIDTH-1:0] tdata_reg;

  logic               dividend_neg;
  logic               divisor_neg;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               core_start;
  logic               core_done;
  logic [WIDTH-1:0]   core_quo;
  logic [WIDTH-1:0]   core_rem;

  // Read as unsigned, -(-2^(WIDTH-1)) is exactly 2^(WIDTH-1), so the magnitude never overflows.
  always_comb begin
    dividend_neg = (SIGNED != 0) && dividend_reg[WIDTH-1];
    divisor_neg  = (SIGNED != 0) && divisor_reg[WIDTH-1];
    dividend_mag = dividend_neg ? -dividend_reg : dividend_reg;
    divisor_mag  = divisor_neg ? -divisor_reg : divisor_reg;
    quo_fix      = zero_reg ? '1 : (q_neg_reg ? -core_quo : core_quo);
    rem_fix      = zero_reg ? dividend_reg : (r_neg_reg ? -core_rem : core_rem);
    core_start   = (state_reg == PREP);
  end

  div_core_unsigned #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (aclk),
    .srst     (areset),
    .start    (core_start),
    .dividend (dividend_mag),
    .divisor  (divisor_mag),
    .done     (core_done),
    .quotient (core_quo),
    .remainder(core_rem)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= IDLE;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      tvalid_reg   <= 1'b0;
      tdata_reg    <= '0;
    end else begin
      tvalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
            dividend_reg <= s_axis_dividend_tdata;
            divisor_reg  <= s_axis_divisor_tdata;
            state_reg    <= PREP;
          end
        end
        PREP: begin
          q_neg_reg <= dividend_neg ^ divisor_neg;
          r_neg_reg <= dividend_neg;
          zero_reg  <= (divisor_reg == '0);
          state_reg <= ITER;
        end
        ITER: begin
          if (core_done) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          tdata_reg  <= {quo_fix, rem_fix};
          tvalid_reg <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis_dout_tvalid = tvalid_reg;
  assign m_axis_dout_tdata  = tdata_reg;

endmodule

// File: tb/tb_axis_divider.sv
// Bench for axis_divider: one unsigned and one signed instance against an arithmetic reference model.
module tb_axis_divider;

  logic        clk = 1'b0;
  logic        areset;

  logic        u_dvs_v, u_dvd_v, u_out_v;
  logic [31:0] u_dvs_d, u_dvd_d;
  logic [63:0] u_out_d;
  logic        s_dvs_v, s_dvd_v, s_out_v;
  logic [31:0] s_dvs_d, s_dvd_d;
  logic [63:0] s_out_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_divider #(.SIGNED(0), .WIDTH(32)) dut_u (
    .aclk                  (clk),
    .areset                (areset),
    .s_axis_divisor_tvalid (u_dvs_v),
    .s_axis_divisor_tdata  (u_dvs_d),
    .s_axis_dividend_tvalid(u_dvd_v),
    .s_axis_dividend_tdata (u_dvd_d),
    .m_axis_dout_tvalid    (u_out_v),
    .m_axis_dout_tdata     (u_out_d)
  );

  axis_divider #(.SIGNED(1), .WIDTH(32)) dut_s (
    .aclk                  (clk),
    .areset                (areset),
    .s_axis_divisor_tvalid (s_dvs_v),
    .s_axis_divisor_tdata  (s_dvs_d),
    .s_axis_dividend_tvalid(s_dvd_v),
    .s_axis_dividend_tdata (s_dvd_d),
    .m_axis_dout_tvalid    (s_out_v),
    .m_axis_dout_tdata     (s_out_d)
  );

  // Reference: {quotient, remainder} from plain integer arithmetic.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!sgn) return {a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic vdvd, input logic vdvs,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      s_dvd_v = vdvd; s_dvs_v = vdvs; s_dvd_d = a; s_dvs_d = b;
    end else begin
      u_dvd_v = vdvd; u_dvs_v = vdvs; u_dvd_d = a; u_dvs_d = b;
    end
  endtask

  // Called just after the accept edge; cyc = number of edges until the strobe is seen, -1 on timeout.
  task automatic wait_result(input bit sel, output int cyc, output logic [63:0] d);
    cyc = -1;
    d   = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sel ? s_out_v : u_out_v) begin
        cyc = i;
        d   = sel ? s_out_d : u_out_d;
        break;
      end
    end
  endtask

  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          cyc;
    logic [63:0] d;
    logic [63:0] exp;
    exp = model(sel, a, b);
    drive(sel, 1'b1, 1'b1, a, b);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_result(sel, cyc, d);
    check({tag, "_lat"}, 64'(cyc), 64'd34);
    check({tag, "_data"}, d, exp);
    @(negedge clk);
    check({tag, "_strobe_low"}, 64'(sel ? s_out_v : u_out_v), 64'd0);
    check({tag, "_hold"}, sel ? s_out_d : u_out_d, exp);
    $display("[TB] %s sgn=%0d a=%h b=%h -> %h (lat %0d)", tag, sel, a, b, d, cyc);
  endtask

  initial begin
    int          cyc, strobes;
    logic [63:0] d, first_d;
    int          first_cyc;
    logic [31:0] a, b;

    areset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check("reset_u_valid", 64'(u_out_v), 64'd0);
    check("reset_u_data", u_out_d, 64'd0);
    check("reset_s_valid", 64'(s_out_v), 64'd0);
    check("reset_s_data", s_out_d, 64'd0);

    // Directed cases.
    run_op(1'b0, 32'd100, 32'd7, "u_100_7");
    check("u_100_7_literal", u_out_d, 64'h0000000E_00000002);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "s_m7_2");
    check("s_m7_2_literal", s_out_d, 64'hFFFFFFFD_FFFFFFFF);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, "s_7_m2");
    check("s_7_m2_literal", s_out_d, 64'hFFFFFFFD_00000001);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf");
    check("s_ovf_literal", s_out_d, 64'h80000000_00000000);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "u_max_1");
    check("u_max_1_literal", u_out_d, 64'hFFFFFFFF_00000000);
    run_op(1'b0, 32'd5, 32'd0, "u_5_0");
    check("u_5_0_literal", u_out_d, 64'hFFFFFFFF_00000005);
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, "s_m5_0");
    check("s_m5_0_literal", s_out_d, 64'hFFFFFFFF_FFFFFFFB);

    // Second operation presented mid-flight is dropped.
    drive(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    strobes = 0; first_cyc = -1; first_d = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 10) drive(1'b0, 1'b1, 1'b1, 32'd9, 32'd3);
      if (i == 11) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      if (u_out_v) begin
        strobes++;
        if (first_cyc < 0) begin
          first_cyc = i;
          first_d   = u_out_d;
        end
      end
    end
    check("busy_strobes", 64'(strobes), 64'd1);
    check("busy_lat", 64'(first_cyc), 64'd34);
    check("busy_data", first_d, model(1'b0, 32'd100, 32'd7));
    $display("[TB] busy_ignore strobes=%0d lat=%0d data=%h", strobes, first_cyc, first_d);

    // Back-to-back: new operation presented during the strobe cycle.
    drive(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_result(1'b0, cyc, d);
    check("b2b_first_lat", 64'(cyc), 64'd34);
    drive(1'b0, 1'b1, 1'b1, 32'd9, 32'd3);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_result(1'b0, cyc, d);
    check("b2b_second_lat", 64'(cyc), 64'd34);
    check("b2b_second_data", d, 64'h00000003_00000000);
    $display("[TB] back_to_back 9/3 lat=%0d data=%h", cyc, d);
    repeat (2) @(negedge clk);

    // Reset mid-operation aborts it.
    drive(1'b0, 1'b1, 1'b1, 32'd1000, 32'd3);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (20) @(negedge clk);
    areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 64'(u_out_v), 64'd0);
    check("rst_mid_data", u_out_d, 64'd0);
    check("rst_mid_s_data", s_out_d, 64'd0);
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u_out_v) strobes++;
    end
    check("rst_mid_no_strobe", 64'(strobes), 64'd0);
    $display("[TB] reset_abort strobes_after=%0d", strobes);
    run_op(1'b0, 32'd1000, 32'd3, "u_after_rst");

    // Only one tvalid at a time: nothing is accepted.
    for (int m = 0; m < 2; m++) begin
      drive(m[0], 1'b1, 1'b0, 32'd50, 32'd5);
      repeat (3) @(negedge clk);
      drive(m[0], 1'b0, 1'b1, 32'd50, 32'd5);
      repeat (3) @(negedge clk);
      drive(m[0], 1'b0, 1'b0, 32'd0, 32'd0);
      strobes = 0;
      for (int i = 0; i < 45; i++) begin
        @(negedge clk);
        if (m[0] ? s_out_v : u_out_v) strobes++;
      end
      check($sformatf("partial_no_accept_%0d", m), 64'(strobes), 64'd0);
      $display("[TB] partial_valid sgn=%0d strobes=%0d", m, strobes);
    end

    // Randomized operands in both modes.
    for (int k = 0; k < 32; k++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        4: b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(k[0], a, b, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
